pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Consumer end of the next-PC interface: takes the candidate addresses from the next-PC adder block (PC4, PC_offset, PCC) and selects one.
- Holds the architectural PC register.
- Runs a fetch/execute handshake with instruction memory.
- Sits between the next-PC adder, the branch comparator/control decoder, and the instruction memory port. It turns the single-cycle datapath into a memory-latency-tolerant core front end.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VEC, 32'h0000_0100, PC loaded when a jump/branch target is misaligned.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- PC4  in  32  PC+4 candidate.
- PC_offset  in  32  PC+Imm candidate (branch/jal target).
- PCC  in  32  (Rs1+Imm)&~1 candidate (jalr target).
- PC_sel  in  2  00 sequential, 01 conditional branch, 10 jal, 11 jalr.
- Br_taken  in  1  branch condition true; used only when PC_sel=01.
- Inst_done  in  1  current instruction has completed; advance PC.
- Halt  in  1  current instruction is ecall/ebreak; stop after it completes.
- Imem_req  out  1  fetch request.
- Imem_addr  out  32  fetch address (= PC).
- Imem_ack  in  1  fetch data valid this cycle.
- Imem_rdata  in  32  fetched instruction word.
- PC  out  32  architectural PC of the instruction being fetched or executed.
- Inst  out  32  latched instruction word.
- Inst_valid  out  1  Inst holds a valid instruction awaiting completion.
- Trap  out  1  one-cycle pulse on a misaligned target.
- Halted  out  1  core stopped.

Behaviour:
- States: IDLE, FETCH, EXEC, HALTED. All registers are reset asynchronously on rst=1.
- Reset values:
  - State = IDLE; PC = RESET_PC; Inst = 0.
  - Inst_valid, Imem_req, Trap, Halted = 0.
- IDLE: lasts exactly one cycle after rst deasserts, then goes to FETCH.
- FETCH:
  - Imem_req=1 and Imem_addr=PC, both combinational from state.
  - Each cycle with Imem_ack=1: Inst<=Imem_rdata, Inst_valid<=1, go to EXEC.
  - Imem_ack=0: stay in FETCH with no limit on wait cycles. The address is held stable.
- EXEC:
  - Imem_req=0 and Inst_valid=1. Waits for Inst_done.
  - Target selection on Inst_done:
    - 00 -> PC4.
    - 01 -> PC_offset if Br_taken, else PC4.
    - 10 -> PC_offset.
    - 11 -> PCC.
  - If target[1:0]!=0: PC<=TRAP_VEC and Trap=1 for exactly that one cycle (registered, asserted in the cycle after Inst_done). Otherwise PC<=target.
  - After Inst_done: Inst_valid<=0, and the next state is FETCH, or HALTED if Halt=1 in the same cycle. When Halt and Inst_done coincide, the PC still updates to the selected target.
  - Halt without Inst_done is ignored.
- HALTED:
  - Halted=1, Imem_req=0, PC frozen.
  - Left only by rst.
- Imem_ack outside FETCH is ignored; Imem_rdata is not captured.
- Inst_done outside EXEC is ignored.
- Trap has priority over Halt for the PC value only; Halt still stops the core.
- rst mid-fetch or mid-exec aborts immediately. A late Imem_ack after reset is ignored because the state is IDLE.
- PC arithmetic: none in this block; all candidates arrive precomputed at 32 bits, and wrap-around is inherited from the adders.

Optional Feature:
- Macro PC_SEQ_RETIRE_CNT_EN.
- When defined:
  - Adds output Retire_cnt (64 bits), reset to 0.
  - Increments by 1 on every Inst_done accepted in EXEC, including trapping and halting instructions.
  - Wraps from 2^64-1 to 0.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset and sequential fetch: rst pulse, ack immediate, PC_sel=00, Inst_done each EXEC.
  - Imem_addr sequence 0x0, 0x4, 0x8.
  - First Imem_req occurs 1 cycle after rst deasserts.
- Branch: PC=0x8, PC_sel=01, PC_offset=0x40, PC4=0xC.
  - Br_taken=1 -> next Imem_addr=0x40.
  - Repeat with Br_taken=0 -> next Imem_addr=0xC.
- Misaligned jalr: PC_sel=11, PCC=0x1002 -> Trap pulses 1 cycle and next Imem_addr=0x100. Contrast with PCC=0x1004 -> no Trap, next Imem_addr=0x1004.
- Memory wait: Imem_ack held low 5 cycles in FETCH -> Imem_req stays 1 and Imem_addr stays stable. Imem_rdata=0x00500093 is captured only on the ack cycle, and Inst then equals it.
- Halt: Halt=1 with Inst_done=1 and PC_sel=10, PC_offset=0x20 -> PC=0x20, Halted=1, Imem_req=0 forever. A further Imem_ack or Inst_done has no effect.
- Reset mid-fetch: rst asserted in FETCH before ack -> PC=RESET_PC and Inst_valid=0 immediately. An ack arriving in IDLE is ignored. With PC_SEQ_RETIRE_CNT_EN defined, Retire_cnt=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// PC sequencer: holds the architectural PC, runs the fetch/execute handshake with
// instruction memory and selects the next PC. Optional retire counter: PC_SEQ_RETIRE_CNT_EN.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC4,
    input  logic [31:0] PC_offset,
    input  logic [31:0] PCC,
    input  logic [1:0]  PC_sel,
    input  logic        Br_taken,
    input  logic        Inst_done,
    input  logic        Halt,
    output logic        Imem_req,
    output logic [31:0] Imem_addr,
    input  logic        Imem_ack,
    input  logic [31:0] Imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] Inst,
    output logic        Inst_valid,
    output logic        Trap,
`ifdef PC_SEQ_RETIRE_CNT_EN
    output logic [63:0] Retire_cnt,
`endif
    output logic        Halted
);

    typedef enum logic [1:0] {StIdle, StFetch, StExec, StHalted} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic        trap_q;
    logic [31:0] target;
    logic        misaligned;
    logic        fetch_ack;
    logic        done;

    assign fetch_ack  = (state_q == StFetch) && Imem_ack;
    assign done       = (state_q == StExec) && Inst_done;
    assign misaligned = (target[1:0] != 2'b00);

    always_comb begin
        target = PC4;
        unique case (PC_sel)
            2'b00: target = PC4;
            2'b01: target = Br_taken ? PC_offset : PC4;
            2'b10: target = PC_offset;
            2'b11: target = PCC;
            default: target = PC4;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   state_d = StFetch;
            StFetch:  if (Imem_ack) state_d = StExec;
            StExec:   if (Inst_done) state_d = Halt ? StHalted : StFetch;
            StHalted: state_d = StHalted;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        Imem_req   = (state_q == StFetch);
        Inst_valid = (state_q == StExec);
        Halted     = (state_q == StHalted);
    end

    // Trap overrides the target PC only; halting is still decided by the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            inst_q <= 32'h0;
            trap_q <= 1'b0;
        end else begin
            trap_q <= done && misaligned;
            if (fetch_ack) begin
                inst_q <= Imem_rdata;
            end
            if (done) begin
                pc_q <= misaligned ? TRAP_VEC : target;
            end
        end
    end

    assign Imem_addr = pc_q;
    assign PC        = pc_q;
    assign Inst      = inst_q;
    assign Trap      = trap_q;

`ifdef PC_SEQ_RETIRE_CNT_EN
    logic [63:0] retire_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_q <= 64'h0;
        end else if (done) begin
            retire_q <= retire_q + 64'h1;
        end
    end

    assign Retire_cnt = retire_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed steps plus randomized instruction
// stream against a transaction-level reference model.
module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC4, PC_offset, PCC;
    logic [1:0]  PC_sel;
    logic        Br_taken, Inst_done, Halt;
    logic        Imem_req;
    logic [31:0] Imem_addr;
    logic        Imem_ack;
    logic [31:0] Imem_rdata;
    logic [31:0] PC, Inst;
    logic        Inst_valid, Trap, Halted;
`ifdef PC_SEQ_RETIRE_CNT_EN
    logic [63:0] Retire_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state: architectural view only.
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    longint unsigned m_retire;

    pc_sequencer #(
        .RESET_PC(RESET_PC),
        .TRAP_VEC(TRAP_VEC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .PC4        (PC4),
        .PC_offset  (PC_offset),
        .PCC        (PCC),
        .PC_sel     (PC_sel),
        .Br_taken   (Br_taken),
        .Inst_done  (Inst_done),
        .Halt       (Halt),
        .Imem_req   (Imem_req),
        .Imem_addr  (Imem_addr),
        .Imem_ack   (Imem_ack),
        .Imem_rdata (Imem_rdata),
        .PC         (PC),
        .Inst       (Inst),
        .Inst_valid (Inst_valid),
        .Trap       (Trap),
`ifdef PC_SEQ_RETIRE_CNT_EN
        .Retire_cnt (Retire_cnt),
`endif
        .Halted     (Halted)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_retire();
`ifdef PC_SEQ_RETIRE_CNT_EN
        check("retire_cnt", Retire_cnt, m_retire);
`endif
    endtask

    // Architectural next-PC rule: pick the candidate, then trap if not word aligned.
    function automatic logic [31:0] model_target(input logic [1:0] sel, input logic taken,
                                                 input logic [31:0] pc4, input logic [31:0] off,
                                                 input logic [31:0] pcc);
        if (sel == 2'd0) return pc4;
        if (sel == 2'd1) return taken ? off : pc4;
        if (sel == 2'd2) return off;
        return pcc;
    endfunction

    // One full instruction: wait states, fetch, some idle exec cycles, completion.
    task automatic do_instr(input int waits, input logic [31:0] rdata, input logic [1:0] sel,
                            input logic taken, input logic [31:0] off, input logic [31:0] pcc,
                            input logic halt);
        logic [31:0] tgt;
        logic        exp_trap;
        check("fetch_req", Imem_req, 1'b1);
        check("fetch_addr", Imem_addr, m_pc);
        for (int i = 0; i < waits; i++) begin
            Imem_ack   = 1'b0;
            Imem_rdata = $urandom;
            tick();
            check("wait_req", Imem_req, 1'b1);
            check("wait_addr", Imem_addr, m_pc);
            check("wait_inst_hold", Inst, m_inst);
        end
        Imem_ack   = 1'b1;
        Imem_rdata = rdata;
        tick();
        Imem_ack = 1'b0;
        m_inst   = rdata;
        check("exec_inst", Inst, m_inst);
        check("exec_valid", Inst_valid, 1'b1);
        check("exec_req", Imem_req, 1'b0);
        for (int i = 0; i < int'($urandom_range(2, 0)); i++) begin
            Halt       = 1'($urandom);
            Imem_ack   = 1'b1;
            Imem_rdata = $urandom;
            tick();
            check("exec_hold_inst", Inst, m_inst);
            check("exec_hold_pc", PC, m_pc);
            check("exec_hold_halted", Halted, 1'b0);
        end
        Imem_ack  = 1'b0;
        PC4       = m_pc + 32'd4;
        PC_offset = off;
        PCC       = pcc;
        PC_sel    = sel;
        Br_taken  = taken;
        Halt      = halt;
        Inst_done = 1'b1;
        tgt       = model_target(sel, taken, m_pc + 32'd4, off, pcc);
        exp_trap  = (tgt % 4) != 0;
        m_pc      = exp_trap ? TRAP_VEC : tgt;
        m_retire++;
        tick();
        Inst_done = 1'b0;
        Halt      = 1'b0;
        check("done_pc", PC, m_pc);
        check("done_trap", Trap, exp_trap);
        check("done_halted", Halted, halt);
        check("done_valid", Inst_valid, 1'b0);
        check("done_req", Imem_req, !halt);
        check_retire();
        tick();
        check("trap_pulse_end", Trap, 1'b0);
    endtask

    initial begin
        logic [31:0] off, pcc;
        rst = 1'b1;
        {PC4, PC_offset, PCC, PC_sel, Br_taken, Inst_done, Halt, Imem_ack, Imem_rdata} = '0;
        m_pc = RESET_PC;
        m_inst = 32'h0;
        m_retire = 0;

        // Reset state and IDLE->FETCH latency.
        repeat (2) tick();
        check("rst_pc", PC, RESET_PC);
        check("rst_inst", Inst, 32'h0);
        check("rst_valid", Inst_valid, 1'b0);
        check("rst_req", Imem_req, 1'b0);
        check("rst_trap", Trap, 1'b0);
        check("rst_halted", Halted, 1'b0);
        check_retire();
        rst = 1'b0;
        check("idle_req", Imem_req, 1'b0);
        tick();
        check("first_req", Imem_req, 1'b1);

        // Sequential fetch 0x0, 0x4, then branch at 0x8.
        do_instr(0, $urandom, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0);
        do_instr(0, $urandom, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("seq_addr_8", Imem_addr, 32'h8);
        do_instr(0, $urandom, 2'd1, 1'b1, 32'h40, 32'h0, 1'b0);
        check("br_taken_addr", Imem_addr, 32'h40);
        do_instr(0, $urandom, 2'd1, 1'b0, 32'h80, 32'h0, 1'b0);
        check("br_not_taken_addr", Imem_addr, 32'h44);

        // jalr misaligned vs aligned.
        do_instr(0, $urandom, 2'd3, 1'b0, 32'h0, 32'h1002, 1'b0);
        check("jalr_trap_addr", Imem_addr, 32'h100);
        do_instr(0, $urandom, 2'd3, 1'b0, 32'h0, 32'h1004, 1'b0);
        check("jalr_ok_addr", Imem_addr, 32'h1004);

        // Memory wait of 5 cycles then capture.
        do_instr(5, 32'h0050_0093, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0);

        // Randomized instruction stream; about a quarter of targets misaligned.
        for (int n = 0; n < 25; n++) begin
            off = {$urandom} & 32'hFFFF_FFFC;
            pcc = {$urandom} & 32'hFFFF_FFFC;
            if ($urandom_range(3, 0) == 0) off[1:0] = 2'($urandom_range(3, 1));
            if ($urandom_range(3, 0) == 0) pcc[1] = 1'b1;
            do_instr(int'($urandom_range(3, 0)), $urandom, 2'($urandom), 1'($urandom),
                     off, pcc, 1'b0);
        end

        // Halt on jal to 0x20; core must then ignore acks and completions.
        do_instr(0, 32'h0000_0073, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1);
        check("halt_pc", PC, 32'h20);
        for (int i = 0; i < 4; i++) begin
            Imem_ack   = 1'b1;
            Imem_rdata = $urandom;
            Inst_done  = 1'b1;
            PC_sel     = 2'd2;
            PC_offset  = 32'h400;
            tick();
            check("halted_stay", Halted, 1'b1);
            check("halted_req", Imem_req, 1'b0);
            check("halted_pc", PC, 32'h20);
            check("halted_inst", Inst, m_inst);
            check_retire();
        end
        Imem_ack  = 1'b0;
        Inst_done = 1'b0;

        // Reset from halted, then reset again mid-fetch (async, no clock edge).
        rst = 1'b1;
        #1;
        m_pc = RESET_PC;
        m_inst = 32'h0;
        m_retire = 0;
        check("rst_halt_clear", Halted, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        Imem_rdata = 32'hDEAD_BEEF;
        repeat (3) tick();
        check("midfetch_req", Imem_req, 1'b1);
        rst = 1'b1;
        #1;
        check("midfetch_pc", PC, RESET_PC);
        check("midfetch_valid", Inst_valid, 1'b0);
        check("midfetch_inst", Inst, 32'h0);
        check("midfetch_req_drop", Imem_req, 1'b0);
        check_retire();
        Imem_ack = 1'b1;
        rst = 1'b0;
        tick();
        Imem_ack = 1'b0;
        check("late_ack_inst", Inst, 32'h0);
        check("late_ack_valid", Inst_valid, 1'b0);
        check("post_rst_req", Imem_req, 1'b1);
        check("post_rst_addr", Imem_addr, RESET_PC);
        do_instr(1, $urandom, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end

endmodule
